// File: rtl/vs_spi_master_if.sv
// Host-side and VS1003-side signals of the SPI master.
// The master modport is the DUT view; the slave modport is the driving side.
interface vs_spi_master_if;
    logic        start;
    logic        mode;
    logic [7:0]  sci_addr;
    logic [15:0] sci_data;
    logic [7:0]  sdi_byte;
    logic        dreq;
    logic        busy;
    logic        done;
    logic        xcs;
    logic        xdcs;
    logic        sclk;
    logic        mosi;

    modport master (
        input  start, mode, sci_addr, sci_data, sdi_byte, dreq,
        output busy, done, xcs, xdcs, sclk, mosi
    );

    modport slave (
        output start, mode, sci_addr, sci_data, sdi_byte, dreq,
        input  busy, done, xcs, xdcs, sclk, mosi
    );
endinterface

// File: rtl/vs_spi_master.sv
// VS1003 SPI master: one SCI write (32-bit, xCS) or SDI byte (8-bit, xDCS)
// per start, gated by synchronised DREQ, mode 0, MSB first.
module vs_spi_master #(
    parameter int HALF = 2
) (
    input  logic               i_clkin,
    input  logic               i_rst,
    vs_spi_master_if.master    io_spi
);
    typedef enum logic [2:0] {
        IDLE, WAIT_DREQ, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
    } state_t;

    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

    state_t      r_state, w_next;
    logic        r_dreq_m, r_dreq_s;
    logic [31:0] r_shift;
    logic [5:0]  r_cnt;
    logic [5:0]  r_n;
    logic [7:0]  r_half;
    logic        r_mode;
    logic        w_half_end;
    logic        w_frame;

    assign w_half_end = (r_half == 8'd0);

    always_ff @(posedge i_clkin or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (io_spi.start) w_next = WAIT_DREQ;
            WAIT_DREQ: if (r_dreq_s)     w_next = SETUP;
            SETUP:     if (w_half_end)   w_next = SHIFT_HI;
            SHIFT_HI:  if (w_half_end)   w_next = SHIFT_LO;
            SHIFT_LO:  if (w_half_end)   w_next = (r_cnt < r_n) ? SHIFT_HI : HOLD;
            HOLD:      if (w_half_end)   w_next = GAP;
            GAP:       if (w_half_end)   w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_comb begin
        w_frame     = (r_state inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});
        io_spi.xcs  = !(w_frame && !r_mode);
        io_spi.xdcs = !(w_frame && r_mode);
        io_spi.sclk = (r_state == SHIFT_HI);
        io_spi.mosi = w_frame && r_shift[31];
        io_spi.busy = (r_state != IDLE);
        io_spi.done = (r_state == GAP) && w_half_end;
    end

    always_ff @(posedge i_clkin or posedge i_rst) begin
        if (i_rst) begin
            r_dreq_m <= 1'b0;
            r_dreq_s <= 1'b0;
        end else begin
            r_dreq_m <= io_spi.dreq;
            r_dreq_s <= r_dreq_m;
        end
    end

    always_ff @(posedge i_clkin or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= 32'd0;
            r_cnt   <= 6'd0;
            r_n     <= 6'd0;
            r_half  <= 8'd0;
            r_mode  <= 1'b0;
        end else begin
            // every timed state starts a fresh half-period on entry
            if (w_next != r_state)   r_half <= HALF_M1;
            else if (!w_half_end)    r_half <= r_half - 8'd1;

            if (r_state == IDLE && io_spi.start) begin
                r_mode  <= io_spi.mode;
                r_cnt   <= 6'd0;
                r_n     <= io_spi.mode ? 6'd8 : 6'd32;
                r_shift <= io_spi.mode ? {io_spi.sdi_byte, 24'h0}
                                       : {8'h02, io_spi.sci_addr, io_spi.sci_data};
            end

            // last bit is not shifted out so mosi holds it through HOLD
            if (r_state == SHIFT_HI && w_next == SHIFT_LO) begin
                r_cnt <= r_cnt + 6'd1;
                if (r_cnt + 6'd1 < r_n) r_shift <= {r_shift[30:0], 1'b0};
            end
        end
    end
endmodule
